// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer sitting behind uart_rx.
// Registered head/valid outputs, registered occupancy count and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [CW-1:0] AfCount   = CW'(AF_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_afCheck
        $error("uart_rx_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rdValid_q, rdValid_d;
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;

    logic push;
    logic pop;
    logic drop;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    always_comb begin
        pop  = rdValid_q && rd_ready;
        push = wr_valid && ((count_q != FullCount) || pop);
        drop = wr_valid && !push;

        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        // The new head is the byte being written only when it is the sole entry left.
        rdValid_d = (count_d != '0);
        rdData_d  = '0;
        if (rdValid_d) begin
            if (push && (rdPtr_d == wrPtr_q)) begin
                rdData_d = wr_data;
            end else begin
                rdData_d = mem[rdPtr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdValid_q  <= 1'b0;
            rdData_q   <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rdValid_q  <= rdValid_d;
            rdData_q   <= rdData_d;
        end
    end

    assign rd_valid    = rdValid_q;
    assign rd_data     = rdData_q;
    assign count       = count_q;
    assign full        = (count_q == FullCount);
    assign almost_full = (count_q >= AfCount);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based model checked every cycle, directed scenarios
// with literal expectations, and a randomized traffic phase.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          overflow;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_ready(rd_ready),
        .count(count),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    int            checkCount = 0;
    int            passCount = 0;
    logic [DW-1:0] modelQ [$];
    logic [DW-1:0] readLog [$];
    bit            modelOvf = 1'b0;
    bit            mPop;
    bit            mPush;
    bit            checkEn = 1'b0;
    bit            trackMax = 1'b0;
    int            maxCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of bytes plus the sticky overflow bit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelQ.delete();
            modelOvf = 1'b0;
        end else begin
            mPop  = (modelQ.size() > 0) && rd_ready;
            mPush = wr_valid && ((modelQ.size() < DEPTH) || mPop);
            if (mPop) readLog.push_back(modelQ.pop_front());
            if (mPush) modelQ.push_back(wr_data);
            if (wr_valid && !mPush) modelOvf = 1'b1;
            else if (clr_overflow) modelOvf = 1'b0;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("count", 32'(count), modelQ.size());
            checkOutput("rd_valid", 32'(rd_valid), 32'(modelQ.size() != 0));
            if (modelQ.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(modelQ[0]));
            checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
            checkOutput("almost_full", 32'(almost_full), 32'(modelQ.size() >= AF));
            checkOutput("overflow", 32'(overflow), 32'(modelOvf));
            if (trackMax && int'(count) > maxCount) maxCount = int'(count);
        end
    end

    task automatic applyStimulus(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit clr);
        wr_valid     = wv;
        wr_data      = wd;
        rd_ready     = rr;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        wr_valid     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic drainAll(input int budget);
        for (int i = 0; i < budget && modelQ.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        if (modelQ.size() > 0) checkOutput("drain_timeout", modelQ.size(), 0);
        rd_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int eeCount;
        logic [DW-1:0] seq6 [3];
        seq6[0] = 8'hB4;
        seq6[1] = 8'hF1;
        seq6[2] = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("reset_rd_valid", 32'(rd_valid), 0);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        // Reset in the middle of a stream discards queued bytes.
        applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0);
        checkOutput("pre_reset_count", 32'(count), 2);
        rst = 1'b1;
        #1;
        checkOutput("in_reset_rd_valid", 32'(rd_valid), 0);
        checkOutput("in_reset_count", 32'(count), 0);
        checkOutput("in_reset_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_reset_rd_valid", 32'(rd_valid), 0);
        checkOutput("post_reset_count", 32'(count), 0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("after_reset_rd_data", 32'(rd_data), 32'h00A5);
        checkOutput("after_reset_rd_valid", 32'(rd_valid), 1);
        drainAll(8);

        // Latency and ordering.
        applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0);
        checkOutput("lat_rd_valid", 32'(rd_valid), 1);
        checkOutput("lat_rd_data", 32'(rd_data), 32'h00B4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0);
        checkOutput("order_count2", 32'(count), 2);
        readLog.delete();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("order_count1", 32'(count), 1);
        checkOutput("order_head_f1", 32'(rd_data), 32'h00F1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("order_count0", 32'(count), 0);
        checkOutput("order_empty", 32'(rd_valid), 0);
        checkOutput("order_log0", 32'(readLog[0]), 32'h00B4);
        rd_ready = 1'b0;

        // Fill, almost-full threshold, pointer wrap.
        readLog.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 12));
            checkOutput("fill_full", 32'(full), 32'(i + 1 == 16));
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 16; i < 24; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("wrap_full", 32'(full), 1);
        drainAll(40);
        checkOutput("wrap_log_size", readLog.size(), 24);
        for (int i = 0; i < 24 && i < readLog.size(); i++) checkOutput("wrap_order", 32'(readLog[i]), i);

        // Overflow and its clear.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(overflow), 1);
        checkOutput("ovf_count", 32'(count), 16);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_clear", 32'(overflow), 0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", 32'(overflow), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_clear2", 32'(overflow), 0);

        // Full with a simultaneous read and write.
        readLog.delete();
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        checkOutput("fullrw_count", 32'(count), 16);
        checkOutput("fullrw_overflow", 32'(overflow), 0);
        checkOutput("fullrw_popped", 32'(readLog[0]), 32'h0030);
        checkOutput("fullrw_head", 32'(rd_data), 32'h0031);
        readLog.delete();
        drainAll(40);
        checkOutput("fullrw_log_size", readLog.size(), 16);
        if (readLog.size() == 16) begin
            checkOutput("fullrw_16th", 32'(readLog[15]), 32'h005A);
            checkOutput("fullrw_15th", 32'(readLog[14]), 32'h003F);
        end
        eeCount = 0;
        foreach (readLog[i]) if (readLog[i] == 8'hEE) eeCount++;
        checkOutput("no_dropped_byte", eeCount, 0);

        // Bytes arriving at UART cadence (10 bits x 130 clocks) with a ready consumer.
        readLog.delete();
        maxCount = 0;
        trackMax = 1'b1;
        rd_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            repeat (1299) @(posedge clk);
            #1;
            applyStimulus(1'b1, seq6[b], 1'b1, 1'b0);
        end
        repeat (20) @(posedge clk);
        #1;
        trackMax = 1'b0;
        rd_ready = 1'b0;
        checkOutput("e2e_log_size", readLog.size(), 3);
        for (int b = 0; b < 3 && b < readLog.size(); b++) checkOutput("e2e_order", 32'(readLog[b]), 32'(seq6[b]));
        checkOutput("e2e_max_count_le1", 32'(maxCount <= 1), 1);
        checkOutput("e2e_overflow", 32'(overflow), 0);

        // Randomized traffic with shifting reader pressure and one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            bit rr;
            if (c == 1500) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            case ((c / 500) % 3)
                0:       rr = ($urandom_range(0, 3) == 0);
                1:       rr = ($urandom_range(0, 3) != 0);
                default: rr = $urandom_range(0, 1) == 1;
            endcase
            applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), rr, $urandom_range(0, 19) == 0);
        end
        drainAll(40);
        checkOutput("final_empty", 32'(rd_valid), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
